// File: rtl/out_bcd_converter_if.sv
// Bus between the CPU output port and the BCD converter.
// Handshake: no valid/ready; `in` is sampled as a level every clock, bcd is held stable, done pulses one cycle per update.
interface out_bcd_converter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DIGITS     = 5
);
   logic [DATA_WIDTH-1:0] in;
   logic                  freeze;
   logic [4*DIGITS-1:0]   bcd;
   logic                  busy;
   logic                  done;

   modport master (output in, freeze, input bcd, busy, done);
   modport slave  (input in, freeze, output bcd, busy, done);
endinterface

// File: rtl/out_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter watching the CPU output word.
// One bit per clock; bcd only updates with a complete result.
module out_bcd_converter #(
   parameter int DATA_WIDTH = 16,
   parameter int DIGITS     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   out_bcd_converter_if.slave bus,
   output logic [1:0]         o_dbg_state
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            r_state;
   logic [DATA_WIDTH-1:0] r_snapshot;
   logic [DATA_WIDTH-1:0] r_bin_sh;
   logic [BW-1:0]         r_scratch;
   logic [BW-1:0]         r_bcd;
   logic [CW-1:0]         r_cnt;
   logic                  r_done;
   logic [BW-1:0]         w_corrected;
   logic                  w_start;

   // Add-3 correction on every nibble in parallel, no carry between nibbles.
   always_comb begin
      w_corrected = r_scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5)
            w_corrected[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
   end

   assign w_start = !bus.freeze && (bus.in != r_snapshot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_snapshot <= '0;
         r_bin_sh   <= '0;
         r_scratch  <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_start) begin
                  r_snapshot <= bus.in;
                  r_bin_sh   <= bus.in;
                  r_scratch  <= '0;
                  r_cnt      <= CW'(DATA_WIDTH);
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_scratch <= {w_corrected[BW-2:0], r_bin_sh[DATA_WIDTH-1]};
               r_bin_sh  <= r_bin_sh << 1;
               r_cnt     <= r_cnt - CW'(1);
               if (r_cnt == CW'(1))
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_bcd   <= r_scratch;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bcd     = r_bcd;
   assign bus.done    = r_done;
   assign bus.busy    = (r_state == S_SHIFT) || (r_state == S_DONE);
   assign o_dbg_state = r_state;
endmodule
